// File: rtl/bias_loader_pkg.sv
// Shared definitions for the parcnn bias path: lane width, loader FSM states
// and the counter-width helper.
package parcnn_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so a single-lane build still has a counter bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bias_loader_if.sv
// Byte stream in, packed bias vector out, plus framing-error status.
interface bias_loader_if #(
    parameter int SIZE = 4
);
    import parcnn_pkg::*;

    logic [LANE_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [SIZE*LANE_W-1:0] bias;
    logic                   bias_valid;
    logic                   bias_ack;
    logic                   err_clear;
    logic                   frame_err;

    modport slave (
        input  in_data, in_valid, in_last, bias_ack, err_clear,
        output in_ready, bias, bias_valid, frame_err
    );

    modport master (
        output in_data, in_valid, in_last, bias_ack, err_clear,
        input  in_ready, bias, bias_valid, frame_err
    );

endinterface

// File: rtl/bias_loader_shadow_buf.sv
// Shadow pack register: one byte lane per index, first index lands in the
// most-significant lane. A clear wipes any partial vector.
module bias_shadow_buf
    import parcnn_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int CW   = clog2(SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   clr,
    input  logic [CW-1:0]          idx,
    input  logic [LANE_W-1:0]      data,
    output logic [SIZE*LANE_W-1:0] vec
);

    for (genvar l = 0; l < SIZE; l++) begin : g_lane
        localparam logic [CW-1:0] LANE_IDX = CW'(SIZE - 1 - l);

        logic [LANE_W-1:0] lane_q;
        logic              sel;

        assign sel = wr_en && (idx == LANE_IDX);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                lane_q <= '0;
            end else if (clr) begin
                lane_q <= '0;
            end else if (sel) begin
                lane_q <= data;
            end
        end

        assign vec[l*LANE_W +: LANE_W] = lane_q;
    end

endmodule

// File: rtl/bias_loader.sv
// Double-buffered bias writer: packs a byte stream into a SIZE-lane vector and
// hands it to the bias adder with a valid/ack hold.
module bias_loader
    import parcnn_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic          clock,
    input  logic          reset,
    bias_loader_if.slave  bus
);

    localparam int            CW       = clog2(SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [SIZE*LANE_W-1:0] shadow;
    logic [SIZE*LANE_W-1:0] bias_q;
    logic                   bias_valid_q;
    logic                   frame_err_q;

    logic accept, at_last, bad, xfer;

    // Ready depends only on the state register, so there is no path from bias_ack.
    assign bus.in_ready = (state == FILL);

    assign accept  = bus.in_valid && bus.in_ready;
    assign at_last = (cnt == LAST_IDX);
    // in_last must coincide exactly with the final lane; any mismatch is a framing error.
    assign bad     = accept && (bus.in_last != at_last);
    assign xfer    = (state == FULL) && (!bias_valid_q || bus.bias_ack);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            FILL: begin
                if (bad) begin
                    cnt_nx = '0;
                end else if (accept) begin
                    if (at_last) begin
                        cnt_nx   = '0;
                        state_nx = FULL;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (xfer) begin
                    cnt_nx   = '0;
                    state_nx = FILL;
                end
            end
            default: begin
                state_nx = FILL;
                cnt_nx   = '0;
            end
        endcase
    end

    bias_shadow_buf #(
        .SIZE (SIZE),
        .CW   (CW)
    ) u_shadow (
        .clock (clock),
        .reset (reset),
        .wr_en (accept && !bad),
        .clr   (bad),
        .idx   (cnt),
        .data  (bus.in_data),
        .vec   (shadow)
    );

    // A transfer in the same cycle as an ack replaces the vector without a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bias_q       <= '0;
            bias_valid_q <= 1'b0;
        end else if (xfer) begin
            bias_q       <= shadow;
            bias_valid_q <= 1'b1;
        end else if (bus.bias_ack) begin
            bias_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else if (bad) begin
            frame_err_q <= 1'b1;
        end else if (bus.err_clear) begin
            frame_err_q <= 1'b0;
        end
    end

    assign bus.bias       = bias_q;
    assign bus.bias_valid = bias_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboarded bench for bias_loader: directed scenarios then randomized framing
// and consumer backpressure against a frame-level reference model.
module tb_bias_loader;
    import parcnn_pkg::*;

    localparam int SIZE = 4;
    localparam int VW   = SIZE * 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bias_loader_if #(.SIZE(SIZE)) bif ();
    bias_loader #(.SIZE(SIZE)) dut (.clock(clock), .reset(reset), .bus(bif));

    int n_tests = 0;
    int n_fail  = 0;

    logic [VW-1:0]     exp_q[$];
    logic [7:0]        part[$];
    int                pos       = 0;
    bit                model_err = 1'b0;

    bit auto_ack = 1'b0;
    bit rnd_ack  = 1'b0;
    bit man_ack  = 1'b0;
    assign bif.bias_ack = auto_ack ? rnd_ack : man_ack;

    always @(posedge clock) begin
        #1;
        rnd_ack = ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_frame();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) v[(SIZE-1-i)*8 +: 8] = part[i];
        return v;
    endfunction

    // Every acknowledged valid vector must be the oldest complete frame sent.
    always @(negedge clock) begin
        if (!reset && bif.bias_valid && bif.bias_ack) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vector: got %0h expected none", bif.bias);
            end else begin
                check("vector", bif.bias, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit last, input bit clr);
        int  t;
        bit  full, err;
        t = 0;
        bif.in_valid  = 1'b1;
        bif.in_data   = d;
        bif.in_last   = last;
        bif.err_clear = clr;
        while (!bif.in_ready && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (!bif.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready %0b expected 1", bif.in_ready);
            bif.in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.err_clear = 1'b0;
        full = (pos == SIZE - 1);
        err  = (last != full);
        if (err) begin
            part.delete();
            pos = 0;
        end else begin
            part.push_back(d);
            if (full) begin
                exp_q.push_back(pack_frame());
                part.delete();
                pos = 0;
            end else begin
                pos++;
            end
        end
        model_err = err ? 1'b1 : (clr ? 1'b0 : model_err);
        check("frame_err", bif.frame_err, model_err);
    endtask

    task automatic ack_pulse();
        man_ack = 1'b1;
        @(posedge clock); #1;
        man_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        int  t;
        bit  last;
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_last   = 1'b0;
        bif.err_clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_bias", bif.bias, 0);
        check("rst_bias_valid", bif.bias_valid, 0);
        check("rst_frame_err", bif.frame_err, 0);
        check("rst_in_ready", bif.in_ready, 1);
        reset = 1'b0;
        tick();

        // Basic pack and 2-cycle latency
        send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0); send(8'd4, 1, 0);
        check("lat_valid_n1", bif.bias_valid, 0);
        check("lat_ready_n1", bif.in_ready, 0);
        tick();
        check("lat_valid_n2", bif.bias_valid, 1);
        check("basic_bias", bif.bias, 32'h01020304);
        check("basic_ready", bif.in_ready, 1);

        // Backpressure while the first vector is held
        send(8'd31, 0, 0); send(8'd28, 0, 0); send(8'd53, 0, 0); send(8'd94, 1, 0);
        repeat (3) tick();
        check("bp_ready", bif.in_ready, 0);
        check("bp_bias_hold", bif.bias, 32'h01020304);
        check("bp_valid", bif.bias_valid, 1);
        ack_pulse();
        check("bp_bias_new", bif.bias, 32'h1F1C355E);
        check("bp_valid_kept", bif.bias_valid, 1);

        // Early last
        send(8'd5, 0, 0); send(8'd6, 1, 0);
        check("early_bias_hold", bif.bias, 32'h1F1C355E);
        send(8'd128, 0, 0); send(8'd128, 0, 0); send(8'd200, 0, 0); send(8'd255, 1, 0);
        ack_pulse();
        check("early_bias_new", bif.bias, 32'h8080C8FF);
        bif.err_clear = 1'b1;
        tick();
        bif.err_clear = 1'b0;
        model_err = 1'b0;
        check("err_clear", bif.frame_err, model_err);

        // Missing last
        send(8'd10, 0, 0); send(8'd20, 0, 0); send(8'd30, 0, 0); send(8'd40, 0, 0);
        check("miss_valid", bif.bias_valid, 1);
        check("miss_ready", bif.in_ready, 1);
        check("miss_bias", bif.bias, 32'h8080C8FF);

        // Ack with nothing pending
        ack_pulse();
        check("ackonly_valid", bif.bias_valid, 0);
        check("ackonly_bias", bif.bias, 32'h8080C8FF);
        tick();
        check("ackonly_hold", bif.bias, 32'h8080C8FF);

        // Reset mid-fill
        send(8'd9, 0, 0); send(8'd9, 0, 0);
        reset = 1'b1;
        part.delete(); pos = 0; model_err = 1'b0; exp_q.delete();
        #1;
        check("mid_rst_bias", bif.bias, 0);
        check("mid_rst_valid", bif.bias_valid, 0);
        check("mid_rst_err", bif.frame_err, 0);
        check("mid_rst_ready", bif.in_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        tick();
        send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0); send(8'd4, 1, 0);
        tick();
        check("post_rst_bias", bif.bias, 32'h01020304);
        check("post_rst_err", bif.frame_err, 0);
        ack_pulse();

        // Randomized framing, error clears and consumer stalls
        auto_ack = 1'b1;
        for (int k = 0; k < 300; k++) begin
            last = (pos == SIZE - 1);
            if ($urandom_range(0, 99) < 8) last = ~last;
            send(8'($urandom_range(0, 255)), last, ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        t = 0;
        while ((exp_q.size() != 0 || bif.bias_valid) && t < 500) begin
            tick();
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_valid", bif.bias_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
